// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with enable; direct-address and auto-scan modes.
// Define DEC_ACTIVE_LOW_EN to drive F as active-low selects (idx and step unaffected).
module scan_decoder #(
    parameter int unsigned AW       = 3,
    parameter int unsigned PRESCALE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              E,
    input  logic              mode,
    input  logic [AW-1:0]     A,
    input  logic [AW-1:0]     scan_last,
    output logic [2**AW-1:0]  F,
    output logic [AW-1:0]     idx,
    output logic              step
);

    localparam int unsigned NO = 2 ** AW;
    localparam int unsigned PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] PreMax = PW'(PRESCALE - 1);

`ifdef DEC_ACTIVE_LOW_EN
    localparam logic [NO-1:0] FOff = '1;
`else
    localparam logic [NO-1:0] FOff = '0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StDirect,
        StScan
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [NO-1:0]   f_q, f_d;
    logic            step_q, step_d;
    logic [AW-1:0]   idx_adv;

    function automatic logic [NO-1:0] onehot(input logic [AW-1:0] i);
        logic [NO-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // idx + 1 wraps naturally in AW bits; a lowered scan_last also forces a wrap.
    assign idx_adv = (idx_q >= scan_last) ? '0 : idx_q + AW'(1);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        idx_d   = idx_q;
        f_d     = f_q;
        step_d  = 1'b0;
        if (!E) begin
            state_d = StIdle;
            pre_d   = '0;
            f_d     = FOff;
        end else if (!mode) begin
            state_d = StDirect;
            pre_d   = '0;
            idx_d   = A;
            f_d     = onehot(A) ^ FOff;
        end else begin
            state_d = StScan;
            unique case (state_q)
                StScan: begin
                    if (pre_q == PreMax) begin
                        pre_d  = '0;
                        idx_d  = idx_adv;
                        f_d    = onehot(idx_adv) ^ FOff;
                        step_d = 1'b1;
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
                default: begin
                    // Fresh scan entry always restarts at index 0.
                    pre_d = '0;
                    idx_d = '0;
                    f_d   = onehot('0) ^ FOff;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pre_q   <= '0;
            idx_q   <= '0;
            f_q     <= FOff;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            f_q     <= f_d;
            step_q  <= step_d;
        end
    end

    assign F    = f_q;
    assign idx  = idx_q;
    assign step = step_q;

endmodule
